// File: rtl/user_clocked_bb_pkg.sv
// ============================================================================
//  Module      : user_clocked_bb_pkg
//  Description : Shared defaults and the counter-width helper for user_clocked_bb.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package user_clocked_bb_pkg;

    localparam int UCBB_DEF_WIDTH  = 4;
    localparam int UCBB_DEF_STABLE = 2;

    // Counter must hold 0..STABLE_CYCLES-1; never narrower than one bit.
    function automatic int ucbb_cnt_w(input int stable);
        int w;
        w = $clog2(stable + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ucbb_bit_sync.sv
// ============================================================================
//  Module      : ucbb_bit_sync
//  Description : One-bit flop chain synchronizer, async active-low reset.
//                Define UCBB_SYNC3_EN for a three-flop chain (default: two).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ucbb_bit_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

`ifdef UCBB_SYNC3_EN
    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_q = r_s3;
`else
    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;
`endif

endmodule

`default_nettype wire

// File: rtl/user_clocked_bb.sv
// ============================================================================
//  Module      : user_clocked_bb
//  Description : Re-times a foreign-domain bus into clkIn and only passes a
//                value after STABLE_CYCLES consecutive equal samples.
//                Optional UCBB_SYNC3_EN selects a three-flop synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module user_clocked_bb
    import user_clocked_bb_pkg::*;
#(
    parameter int WIDTH         = UCBB_DEF_WIDTH,
    parameter int STABLE_CYCLES = UCBB_DEF_STABLE
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    localparam int              CNT_W      = ucbb_cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
            ucbb_bit_sync u_sync (
                .i_clk   (clkIn),
                .i_rst_n (rst),
                .i_d     (in[gi]),
                .o_q     (w_sync[gi])
            );
        end
    endgenerate

    // A changed sample restarts the count; the counter saturates once the
    // candidate qualifies, so out keeps reloading the same value.
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            r_cand <= '0;
            r_cnt  <= '0;
            r_out  <= '0;
        end else if (w_sync != r_cand) begin
            r_cand <= w_sync;
            r_cnt  <= '0;
        end else if (r_cnt < c_cnt_last) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end else begin
            r_out  <= r_cand;
        end
    end

    assign out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_user_clocked_bb.sv
// ============================================================================
//  Module      : tb_user_clocked_bb
//  Description : Scoreboard bench for user_clocked_bb (STABLE_CYCLES 2 and 1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_user_clocked_bb;

`ifdef UCBB_SYNC3_EN
    localparam int SYNC_D = 3;
`else
    localparam int SYNC_D = 2;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [3:0] dout0;
    logic [3:0] dout1;

    int checks = 0;
    int errors = 0;

    logic [3:0] samp[$];
    logic [3:0] xs[$];
    logic [3:0] exp0;
    logic [3:0] exp1;
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    user_clocked_bb #(.WIDTH(4), .STABLE_CYCLES(2)) dut (
        .clkIn (clk),
        .rst   (rst),
        .in    (din),
        .out   (dout0)
    );

    user_clocked_bb #(.WIDTH(4), .STABLE_CYCLES(1)) dut1 (
        .clkIn (clk),
        .rst   (rst),
        .in    (din),
        .out   (dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: out becomes v once the last S+1 values seen by the filter
    // are all v; after reset the filter behaves as if it just loaded 0.
    task automatic reset_model();
        samp.delete();
        xs.delete();
        for (int i = 0; i < SYNC_D; i++) samp.push_back(4'h0);
        xs.push_back(4'h0);
        exp0 = 4'h0;
        exp1 = 4'h0;
    endtask

    function automatic bit last_equal(input int n);
        if (xs.size() < n) return 1'b0;
        for (int i = 0; i < n; i++)
            if (xs[xs.size() - 1 - i] != xs[xs.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge rst) reset_model();

    always @(posedge clk) begin
        logic [3:0] x;
        if (!rst) begin
            reset_model();
        end else begin
            x = (samp.size() >= SYNC_D) ? samp[samp.size() - SYNC_D] : 4'h0;
            samp.push_back(din);
            if (samp.size() > 8) void'(samp.pop_front());
            xs.push_back(x);
            if (xs.size() > 4) void'(xs.pop_front());
            if (last_equal(3)) exp0 = x;
            if (last_equal(2)) exp1 = x;
        end
        q0.push_back(exp0);
        q1.push_back(exp1);
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if (dout0 !== e) begin
                errors++;
                $display("FAIL out_stable2 t=%0t got %h expected %h", $time, dout0, e);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (dout1 !== e) begin
                errors++;
                $display("FAIL out_stable1 t=%0t got %h expected %h", $time, dout1, e);
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (dout0 !== 4'h0 || dout1 !== 4'h0) begin
            errors++;
            $display("FAIL %s got %h/%h expected 0/0", name, dout0, dout1);
        end
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        din = 4'hF;
        #2 check_zero("reset_no_clock");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din = (i % 2 == 0) ? 4'h0 : 4'hF;
        end
        @(negedge clk);
        rst = 1'b1;
        din = 4'h0;
        repeat (3) @(negedge clk);

        hold(4'h5, 10);
        hold(4'hA, 1);
        hold(4'h5, 10);

        hold(4'h3, 4);
        #1 rst = 1'b0;
        #1 check_zero("midop_reset");
        @(negedge clk);
        rst = 1'b1;
        hold(4'h3, 10);

        hold(4'h1, 10);
        hold(4'h2, 10);
        hold(4'h2, 3);

        repeat (150) hold(4'($urandom_range(0, 15)), $urandom_range(1, 4));

        for (int i = 0; i < 4; i++) begin
            hold(4'($urandom_range(0, 15)), 6);
            #1 rst = 1'b0;
            #1 check_zero("random_reset");
            @(negedge clk);
            rst = 1'b1;
            repeat (20) hold(4'($urandom_range(0, 15)), $urandom_range(1, 3));
        end

        hold(4'h7, 8);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
